// File: rtl/over_pixel_packer.sv
// Packs a raster stream of 4-bit palette indices into 32-bit overlay words (8 px/word),
// or fills the whole overlay frame with one constant index.
module over_pixel_packer #(
    parameter int WORDS_PER_ROW = 40,
    parameter int ROWS          = 64
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        Clear,
    input  logic [3:0]  Fill_idx,
    input  logic        Pix_valid,
    input  logic [3:0]  Pix_data,
    output logic        Pix_ready,
    output logic        Wr_en,
    output logic [11:0] Wr_addr,
    output logic [31:0] Wr_data,
    output logic        Busy,
    output logic        Done
);

    localparam int              TOTAL     = WORDS_PER_ROW * ROWS;
    localparam int              CW        = $clog2(TOTAL + 1);
    localparam logic [CW-1:0]   TOTAL_C   = CW'(TOTAL);
    localparam logic [11:0]     LAST_ADDR = 12'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FILL} state_t;

    state_t         state_reg, state_next;
    logic [2:0]     slot_reg;
    logic [CW-1:0]  cnt_reg;
    logic [3:0]     pix_reg [7];
    logic [27:0]    pix_flat;
    logic [3:0]     fill_reg;
    logic           wr_en_reg;
    logic [11:0]    wr_addr_reg;
    logic [31:0]    wr_data_reg;
    logic           done_reg;

    logic           frame_end;
    logic           has_room;
    logic           accept;

    // The frame ends on the cycle the last address is actually on the bus.
    assign frame_end = wr_en_reg && (wr_addr_reg == LAST_ADDR);
    assign has_room  = (cnt_reg != TOTAL_C);
    assign accept    = (state_reg == LOAD) && Pix_valid && has_room;

    always_comb begin
        state_next = state_reg;
        Pix_ready  = 1'b0;
        Busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start)      state_next = LOAD;
                else if (Clear) state_next = FILL;
            end
            LOAD: begin
                Pix_ready = 1'b1;
                Busy      = 1'b1;
                if (frame_end) state_next = IDLE;
            end
            FILL: begin
                Busy = 1'b1;
                if (frame_end) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Slots 0..6 are buffered; slot 7 goes straight from the input into the word.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_slot
            always_ff @(posedge Clk) begin
                if (!Reset_n) begin
                    pix_reg[gi] <= 4'd0;
                end else if (accept && (slot_reg == 3'(gi))) begin
                    pix_reg[gi] <= Pix_data;
                end
            end
            assign pix_flat[gi*4 +: 4] = pix_reg[gi];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg   <= IDLE;
            slot_reg    <= 3'd0;
            cnt_reg     <= '0;
            fill_reg    <= 4'd0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 12'd0;
            wr_data_reg <= 32'd0;
            done_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            wr_en_reg <= 1'b0;
            done_reg  <= frame_end;

            if (state_reg == IDLE) begin
                slot_reg <= 3'd0;
                cnt_reg  <= '0;
                if (!Start && Clear) fill_reg <= Fill_idx;
            end

            if (accept) begin
                slot_reg <= slot_reg + 3'd1;
                if (slot_reg == 3'd7) begin
                    wr_en_reg   <= 1'b1;
                    wr_data_reg <= {Pix_data, pix_flat};
                    wr_addr_reg <= 12'(cnt_reg);
                    cnt_reg     <= cnt_reg + CW'(1);
                end
            end

            if ((state_reg == FILL) && has_room) begin
                wr_en_reg   <= 1'b1;
                wr_data_reg <= {8{fill_reg}};
                wr_addr_reg <= 12'(cnt_reg);
                cnt_reg     <= cnt_reg + CW'(1);
            end
        end
    end

    assign Wr_en   = wr_en_reg;
    assign Wr_addr = wr_addr_reg;
    assign Wr_data = wr_data_reg;
    assign Done    = done_reg;

endmodule

// File: tb/tb_over_pixel_packer.sv
// Directed bench for over_pixel_packer: word packing, full frame with gaps, fill,
// Start/Clear priority, mid-word reset and Start ignored during a load.
module tb_over_pixel_packer;

    localparam int TOTAL_WORDS = 2560;
    localparam int TOTAL_PIX   = TOTAL_WORDS * 8;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Clear = 1'b0;
    logic [3:0]  Fill_idx = 4'd0;
    logic        Pix_valid = 1'b0;
    logic [3:0]  Pix_data = 4'd0;
    logic        Pix_ready;
    logic        Wr_en;
    logic [11:0] Wr_addr;
    logic [31:0] Wr_data;
    logic        Busy;
    logic        Done;

    int n_cmp  = 0;
    int n_fail = 0;

    over_pixel_packer #(.WORDS_PER_ROW(40), .ROWS(64)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Clear     (Clear),
        .Fill_idx  (Fill_idx),
        .Pix_valid (Pix_valid),
        .Pix_data  (Pix_data),
        .Pix_ready (Pix_ready),
        .Wr_en     (Wr_en),
        .Wr_addr   (Wr_addr),
        .Wr_data   (Wr_data),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int          pix_sent, exp_addr, writes, cnt;
    int          addr_err, data_err, timing_err, busy_err, gap_err;
    int          last_wr_cyc;
    bit          done_seen, v, wr_due;
    logic [31:0] word;

    initial begin
        // Reset state
        Reset_n = 1'b0;
        tick;
        tick;
        chk("rst_pix_ready", 32'(Pix_ready), 32'd0);
        chk("rst_wr_en",     32'(Wr_en),     32'd0);
        chk("rst_wr_addr",   32'(Wr_addr),   32'd0);
        chk("rst_wr_data",   Wr_data,        32'd0);
        chk("rst_busy",      32'(Busy),      32'd0);
        chk("rst_done",      32'(Done),      32'd0);
        Reset_n = 1'b1;
        tick;

        // First word: pixels 1..8 back-to-back
        Start = 1'b1;
        tick;
        Start = 1'b0;
        chk("load_pix_ready", 32'(Pix_ready), 32'd1);
        chk("load_busy",      32'(Busy),      32'd1);
        for (int i = 1; i <= 8; i++) begin
            Pix_valid = 1'b1;
            Pix_data  = 4'(i);
            word[4*(i-1) +: 4] = 4'(i);
            tick;
            if (i == 7) chk("no_early_write", 32'(Wr_en), 32'd0);
        end
        Pix_valid = 1'b0;
        $display("word0 write: en=%0d addr=%0d data=%h", Wr_en, Wr_addr, Wr_data);
        chk("word0_wr_en",   32'(Wr_en),   32'd1);
        chk("word0_wr_addr", 32'(Wr_addr), 32'd0);
        chk("word0_wr_data", Wr_data,      32'h87654321);
        tick;
        chk("word0_pulse_end", 32'(Wr_en),   32'd0);
        chk("word0_data_hold", Wr_data,      32'h87654321);
        chk("word0_addr_hold", 32'(Wr_addr), 32'd0);

        // Rest of the frame with random gaps; Start pulsed mid-load must be ignored
        pix_sent = 8; exp_addr = 1; writes = 1;
        addr_err = 0; data_err = 0; timing_err = 0; busy_err = 0;
        last_wr_cyc = -10; done_seen = 1'b0;
        for (int cyc = 0; cyc < 40000 && !done_seen; cyc++) begin
            v = (pix_sent < TOTAL_PIX) && ($urandom_range(0, 3) != 0);
            Pix_valid = v;
            Pix_data  = 4'((pix_sent * 7 + 3) % 16);
            Start     = (pix_sent == 1000) || (pix_sent == 1001);
            if (v) word[4*(pix_sent % 8) +: 4] = Pix_data;
            wr_due = v && (pix_sent % 8 == 7);
            if (v) pix_sent++;
            tick;
            if (Wr_en) begin
                writes++;
                if (!wr_due) timing_err++;
                if (Wr_addr !== 12'(exp_addr)) addr_err++;
                if (Wr_data !== word) data_err++;
                if (Busy !== 1'b1) busy_err++;
                exp_addr++;
                last_wr_cyc = cyc;
            end else if (wr_due) begin
                timing_err++;
            end
            if (Done) begin
                done_seen = 1'b1;
                chk("frame_done_after_last", 32'(cyc - last_wr_cyc), 32'd1);
                chk("frame_done_busy",       32'(Busy),              32'd0);
            end
        end
        Start = 1'b0;
        Pix_valid = 1'b0;
        $display("frame load: writes=%0d addr_err=%0d data_err=%0d timing_err=%0d",
                 writes, addr_err, data_err, timing_err);
        chk("frame_done_seen",  32'(done_seen),  32'd1);
        chk("frame_writes",     32'(writes),     32'(TOTAL_WORDS));
        chk("frame_addr_err",   32'(addr_err),   32'd0);
        chk("frame_data_err",   32'(data_err),   32'd0);
        chk("frame_timing_err", 32'(timing_err), 32'd0);
        chk("frame_busy_err",   32'(busy_err),   32'd0);
        chk("frame_last_addr",  32'(Wr_addr),    32'd2559);
        tick;
        chk("frame_done_pulse_end", 32'(Done), 32'd0);
        chk("frame_idle_busy",      32'(Busy), 32'd0);

        // Start and Clear together: LOAD wins, no fill writes
        Start = 1'b1; Clear = 1'b1; Fill_idx = 4'h5;
        tick;
        Start = 1'b0; Clear = 1'b0;
        chk("both_pix_ready", 32'(Pix_ready), 32'd1);
        chk("both_busy",      32'(Busy),      32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (Wr_en) cnt++;
        end
        $display("start+clear: writes in 20 idle-input cycles=%0d", cnt);
        chk("both_no_fill_writes", 32'(cnt),       32'd0);
        chk("both_still_load",     32'(Pix_ready), 32'd1);

        // Reset after 5 pixels of a word: nothing written, next frame starts at 0
        cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            Pix_valid = 1'b1;
            Pix_data  = 4'(i);
            tick;
            if (Wr_en) cnt++;
        end
        Pix_valid = 1'b0;
        Reset_n = 1'b0;
        tick;
        if (Wr_en) cnt++;
        chk("midrst_no_write",  32'(cnt),       32'd0);
        chk("midrst_busy",      32'(Busy),      32'd0);
        chk("midrst_pix_ready", 32'(Pix_ready), 32'd0);
        chk("midrst_done",      32'(Done),      32'd0);
        Reset_n = 1'b1;
        tick;
        Start = 1'b1;
        tick;
        Start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            Pix_valid = 1'b1;
            Pix_data  = 4'(16 - i);
            tick;
        end
        Pix_valid = 1'b0;
        $display("restart write: en=%0d addr=%0d data=%h", Wr_en, Wr_addr, Wr_data);
        chk("restart_wr_en",   32'(Wr_en),   32'd1);
        chk("restart_wr_addr", 32'(Wr_addr), 32'd0);
        chk("restart_wr_data", Wr_data,      32'h89ABCDEF);
        Reset_n = 1'b0;
        tick;
        Reset_n = 1'b1;
        tick;

        // Pix_valid in IDLE is ignored
        cnt = 0;
        Pix_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            Pix_data = 4'(i);
            tick;
            if (Wr_en || Busy) cnt++;
        end
        Pix_valid = 1'b0;
        chk("idle_ignores_pixels", 32'(cnt), 32'd0);

        // Constant fill with index A; Fill_idx changed after accept must not matter
        Fill_idx = 4'hA; Clear = 1'b1;
        tick;
        Clear = 1'b0; Fill_idx = 4'h3;
        chk("fill_busy",       32'(Busy),      32'd1);
        chk("fill_pix_ready",  32'(Pix_ready), 32'd0);
        chk("fill_entry_noen", 32'(Wr_en),     32'd0);
        writes = 0; addr_err = 0; data_err = 0; gap_err = 0;
        last_wr_cyc = -10; done_seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            tick;
            if (Wr_en) begin
                if (Wr_addr !== 12'(writes)) addr_err++;
                if (Wr_data !== 32'hAAAAAAAA) data_err++;
                if (cyc != writes) gap_err++;
                writes++;
                last_wr_cyc = cyc;
            end
            if (Done) begin
                done_seen = 1'b1;
                chk("fill_done_after_last", 32'(cyc - last_wr_cyc), 32'd1);
                chk("fill_done_busy",       32'(Busy),              32'd0);
            end
        end
        $display("fill frame: writes=%0d addr_err=%0d data_err=%0d gap_err=%0d",
                 writes, addr_err, data_err, gap_err);
        chk("fill_done_seen", 32'(done_seen), 32'd1);
        chk("fill_writes",    32'(writes),    32'(TOTAL_WORDS));
        chk("fill_addr_err",  32'(addr_err),  32'd0);
        chk("fill_data_err",  32'(data_err),  32'd0);
        chk("fill_gap_err",   32'(gap_err),   32'd0);
        tick;
        chk("fill_done_pulse_end", 32'(Done),  32'd0);
        chk("fill_idle_no_write",  32'(Wr_en), 32'd0);
        chk("fill_data_hold",      Wr_data,    32'hAAAAAAAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
